// File: rtl/asic_unlock_detector.sv
// asic_unlock_detector
// Responder side of the Plus ASIC unlock handshake. Watches CPU I/O writes
// to the CRTC register-select port (&BCxx) and matches the 17-byte ACID
// sequence (a non-zero byte, 00, then the 15-byte table). Drives
// acid_unlocked for the ASIC register block and relocks when the final
// table position sees the wrong byte.
//
// Ports
//   clk_sys        system clock, all state on its rising edge
//   reset_n        asynchronous active-low reset
//   plus_mode      Plus features enabled; low forces locked and IDLE
//   cpu_addr       CPU address bus
//   cpu_data_in    CPU write data
//   cpu_iowr       CPU I/O write strobe (level, held one or more cycles)
//   acid_unlocked  ASIC register page accessible
//   seq_index      current match position 0..16 (debug)
//   unlock_pulse   one-cycle pulse when the unlock completes
//   lock_pulse     one-cycle pulse when an unlocked ASIC relocks
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing seen since reset / plus_mode low
// SYNC  | last accepted byte was non-zero, waiting for the 00 sync byte
// MATCH | comparing against table[seq_index], seq_index 1..15
// DONE  | full sequence matched, seq_index parked at 16

module asic_unlock_detector #(
   parameter bit UNLOCK_AT_RESET = 1'b0,
   parameter bit EDGE_WR         = 1'b1
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        plus_mode,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_iowr,
   output logic        acid_unlocked,
   output logic [4:0]  seq_index,
   output logic        unlock_pulse,
   output logic        lock_pulse
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      MATCH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  seq_index_q, seq_index_d;
   logic        unlocked_q, unlocked_d;
   logic        unlock_pulse_q, unlock_pulse_d;
   logic        lock_pulse_q, lock_pulse_d;
   logic        iowr_q, iowr_d;

   logic        crtc_sel;
   logic        strobe;
   logic        acc;
   logic        data_zero;
   logic [7:0]  expected_byte;
   logic        unused_addr;

   // Only A14, A9 and A8 take part in the CRTC select decode.
   assign unused_addr = ^{cpu_addr[15], cpu_addr[13:10], cpu_addr[7:0]};

   function automatic logic [7:0] seq_byte(input logic [4:0] idx);
      case (idx)
         5'd1:    seq_byte = 8'hFF;
         5'd2:    seq_byte = 8'h77;
         5'd3:    seq_byte = 8'hB3;
         5'd4:    seq_byte = 8'h51;
         5'd5:    seq_byte = 8'hA8;
         5'd6:    seq_byte = 8'hD4;
         5'd7:    seq_byte = 8'h62;
         5'd8:    seq_byte = 8'h39;
         5'd9:    seq_byte = 8'h9C;
         5'd10:   seq_byte = 8'h46;
         5'd11:   seq_byte = 8'h2B;
         5'd12:   seq_byte = 8'h15;
         5'd13:   seq_byte = 8'h8A;
         5'd14:   seq_byte = 8'hCD;
         5'd15:   seq_byte = 8'hEE;
         default: seq_byte = 8'h00;
      endcase
   endfunction

   always_comb begin
      crtc_sel      = ~cpu_addr[14] & ~cpu_addr[9] & ~cpu_addr[8];
      strobe        = EDGE_WR ? (cpu_iowr & ~iowr_q) : cpu_iowr;
      acc           = crtc_sel & strobe;
      data_zero     = (cpu_data_in == 8'h00);
      expected_byte = seq_byte(seq_index_q);

      state_d        = state_q;
      seq_index_d    = seq_index_q;
      unlocked_d     = unlocked_q;
      unlock_pulse_d = 1'b0;
      lock_pulse_d   = 1'b0;
      iowr_d         = cpu_iowr;

      if (!plus_mode) begin
         state_d     = IDLE;
         seq_index_d = 5'd0;
         unlocked_d  = 1'b0;
      end else if (acc) begin
         case (state_q)
            IDLE: begin
               if (!data_zero) state_d = SYNC;
            end
            SYNC: begin
               if (data_zero) begin
                  state_d     = MATCH;
                  seq_index_d = 5'd1;
               end
            end
            MATCH: begin
               if (cpu_data_in == expected_byte) begin
                  if (seq_index_q == 5'd15) begin
                     unlocked_d     = 1'b1;
                     unlock_pulse_d = 1'b1;
                     state_d        = DONE;
                     seq_index_d    = 5'd16;
                  end else begin
                     seq_index_d = seq_index_q + 5'd1;
                  end
               end else begin
                  // A wrong final byte is the relock command.
                  if (seq_index_q == 5'd15) begin
                     unlocked_d   = 1'b0;
                     lock_pulse_d = unlocked_q;
                  end
                  if (data_zero) begin
                     seq_index_d = 5'd1;
                  end else begin
                     state_d     = SYNC;
                     seq_index_d = 5'd0;
                  end
               end
            end
            DONE: begin
               if (data_zero) begin
                  state_d     = MATCH;
                  seq_index_d = 5'd1;
               end else begin
                  state_d     = SYNC;
                  seq_index_d = 5'd0;
               end
            end
            default: begin
               state_d     = IDLE;
               seq_index_d = 5'd0;
            end
         endcase
      end
   end

   // iowr_q resets high so a write already in flight at reset release is
   // not seen as a rising edge; it is only re-armed once cpu_iowr falls.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         seq_index_q    <= 5'd0;
         unlocked_q     <= UNLOCK_AT_RESET;
         unlock_pulse_q <= 1'b0;
         lock_pulse_q   <= 1'b0;
         iowr_q         <= 1'b1;
      end else begin
         state_q        <= state_d;
         seq_index_q    <= seq_index_d;
         unlocked_q     <= unlocked_d;
         unlock_pulse_q <= unlock_pulse_d;
         lock_pulse_q   <= lock_pulse_d;
         iowr_q         <= iowr_d;
      end
   end

   assign acid_unlocked = unlocked_q;
   assign seq_index     = seq_index_q;
   assign unlock_pulse  = unlock_pulse_q;
   assign lock_pulse    = lock_pulse_q;

endmodule
